// File: rtl/simple_ram_pkg.sv
// Shared definitions for the simple_ram block.
// Holds the default word and address widths, the clear-sequencer state
// encoding, and a helper that sizes the clear counter from DEPTH.
package simple_ram_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Counter must reach DEPTH-1; a one-word memory still needs a 1-bit counter.
  function automatic int clr_cnt_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/simple_ram_clr_seq.sv
// Post-reset clear sequencer for simple_ram.
// After rst is released it emits one write of zero per cycle to locations
// 0 .. DEPTH-1, then parks in READY.
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset, restarts the sweep at 0
//   clr_we    - write strobe for the clear write of this cycle
//   clr_addr  - location being cleared this cycle
//   init_busy - registered, high from reset until the last location is cleared
module simple_ram_clr_seq
  import simple_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  localparam int               CNT_W    = clr_cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  clr_state_e       state_r;
  clr_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;
  logic             clr_we_s;

  // State, counter and busy flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Next-state logic: sweep the counter, drop busy on the edge that clears the last word.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    busy_nxt_s  = busy_r;
    clr_we_s    = 1'b0;
    case (state_r)
      CLEAR: begin
        clr_we_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = READY;
          cnt_nxt_s   = {CNT_W{1'b0}};
          busy_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s  = cnt_r + CNT_W'(1'b1);
          busy_nxt_s = 1'b1;
        end
      end
      READY: begin
        busy_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s = CLEAR;
        cnt_nxt_s   = {CNT_W{1'b0}};
        busy_nxt_s  = 1'b1;
      end
    endcase
  end

  // The reset cycle itself must leave memory untouched.
  assign clr_we    = clr_we_s & ~rst;
  assign clr_addr  = ADDR_WIDTH'(cnt_r);
  assign init_busy = busy_r;

endmodule

// File: rtl/simple_ram.sv
// Single-port synchronous RAM with registered read data and write-through.
// A clear sequencer zeroes every word after reset; user accesses are ignored
// while init_busy is high.
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   we        - write enable (1 = write data_in to addr)
//   addr      - shared read/write word address
//   data_in   - write data
//   data_out  - registered read data (write data on a write cycle, 0 when out of range)
//   init_busy - high during reset and the clear sweep
module simple_ram
  import simple_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  init_busy
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  clr_we_s;
  logic [ADDR_WIDTH-1:0] clr_addr_s;
  logic                  init_busy_s;
  logic                  in_range_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  simple_ram_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we_s),
    .clr_addr  (clr_addr_s),
    .init_busy (init_busy_s)
  );

  assign in_range_s = ({1'b0, addr} < DEPTH_L);

  // Storage write port: the clear sweep owns it while busy, the user port otherwise.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = clr_addr_s;
    mem_wdata_s = {DATA_WIDTH{1'b0}};
    if (init_busy_s) begin
      mem_we_s    = clr_we_s;
      mem_addr_s  = clr_addr_s;
      mem_wdata_s = {DATA_WIDTH{1'b0}};
    end else begin
      mem_we_s    = we & in_range_s & ~rst;
      mem_addr_s  = addr;
      mem_wdata_s = data_in;
    end
  end

  // Storage array: no reset term so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  // Registered read data with write-through; out-of-range accesses return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= {DATA_WIDTH{1'b0}};
    end else if (init_busy_s || !in_range_s) begin
      data_out_r <= {DATA_WIDTH{1'b0}};
    end else if (we) begin
      data_out_r <= data_in;
    end else begin
      data_out_r <= mem_r[addr];
    end
  end

  assign data_out  = data_out_r;
  assign init_busy = init_busy_s;

endmodule

// File: tb/tb_simple_ram.sv
// Self-checking bench for simple_ram: a full-depth instance (DEPTH=16) and a
// short instance (DEPTH=12) driven from one table of vectors.
module tb_simple_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst16, we16, busy16;
  logic [3:0] addr16;
  logic [7:0] din16, dout16;
  logic       rst12, we12, busy12;
  logic [3:0] addr12;
  logic [7:0] din12, dout12;

  simple_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) u_ram16 (
    .clk(clk), .rst(rst16), .we(we16), .addr(addr16), .data_in(din16),
    .data_out(dout16), .init_busy(busy16)
  );

  simple_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12)) u_ram12 (
    .clk(clk), .rst(rst12), .we(we12), .addr(addr12), .data_in(din12),
    .data_out(dout12), .init_busy(busy12)
  );

  typedef struct {
    logic       sel;       // 0 = DEPTH 16 instance, 1 = DEPTH 12 instance
    logic       rst;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_busy;
    string      tag;
  } vec_t;

  typedef struct {
    int         idx;
    logic       sel;
    logic [7:0] dout;
    logic       busy;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(input logic sel, input logic r, input logic w,
                              input logic [3:0] a, input logic [7:0] d,
                              input logic [7:0] ed, input logic eb, input string tag);
    vec_t v;
    v.sel = sel; v.rst = r; v.we = w; v.addr = a; v.din = d;
    v.exp_dout = ed; v.exp_busy = eb; v.tag = tag;
    vecs.push_back(v);
  endfunction

  initial begin
    exp_t       e;
    logic [7:0] got_d;
    logic       got_b;

    rst16 = 1'b1; we16 = 1'b0; addr16 = 4'd0; din16 = 8'h00;
    rst12 = 1'b1; we12 = 1'b0; addr12 = 4'd0; din12 = 8'h00;

    // ---- DEPTH 16 instance ----
    add(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, "reset");
    add(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, "reset");
    // Clear sweep with a write attempt to addr 2 on every busy cycle.
    for (int i = 0; i < 16; i++)
      add(1'b0, 1'b0, 1'b1, 4'd2, 8'h77, 8'h00, (i < 15) ? 1'b1 : 1'b0, "clear");
    for (int i = 0; i < 16; i++)
      add(1'b0, 1'b0, 1'b0, 4'(i), 8'h00, 8'h00, 1'b0, "read_zero");
    add(1'b0, 1'b0, 1'b1, 4'd4,  8'hAA, 8'hAA, 1'b0, "wr4");
    add(1'b0, 1'b0, 1'b1, 4'd8,  8'h55, 8'h55, 1'b0, "wr8");
    add(1'b0, 1'b0, 1'b1, 4'd15, 8'hFF, 8'hFF, 1'b0, "wr15");
    add(1'b0, 1'b0, 1'b1, 4'd0,  8'h00, 8'h00, 1'b0, "wr0");
    add(1'b0, 1'b0, 1'b0, 4'd4,  8'h00, 8'hAA, 1'b0, "rd4");
    add(1'b0, 1'b0, 1'b0, 4'd8,  8'h00, 8'h55, 1'b0, "rd8");
    add(1'b0, 1'b0, 1'b0, 4'd15, 8'h00, 8'hFF, 1'b0, "rd15");
    add(1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 8'h00, 1'b0, "rd0");
    add(1'b0, 1'b0, 1'b1, 4'd3,  8'h3C, 8'h3C, 1'b0, "wthru");
    add(1'b0, 1'b0, 1'b0, 4'd3,  8'h00, 8'h3C, 1'b0, "rd3");
    add(1'b0, 1'b0, 1'b1, 4'd9,  8'hC3, 8'hC3, 1'b0, "wr9");
    add(1'b0, 1'b0, 1'b0, 4'd9,  8'h00, 8'hC3, 1'b0, "rd9");
    // Reset, 5 clear cycles, reset again: sweep must restart from 0.
    add(1'b0, 1'b1, 1'b1, 4'd8, 8'h11, 8'h00, 1'b1, "rst_a");
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 1'b0, 4'd8, 8'h00, 8'h00, 1'b1, "part_clr");
    add(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, "rst_b");
    for (int i = 0; i < 16; i++)
      add(1'b0, 1'b0, 1'b0, 4'd15, 8'h00, 8'h00, (i < 15) ? 1'b1 : 1'b0, "reclear");
    for (int i = 0; i < 16; i++)
      add(1'b0, 1'b0, 1'b0, 4'(i), 8'h00, 8'h00, 1'b0, "reread_zero");

    // ---- DEPTH 12 instance ----
    add(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, "r12_reset");
    for (int i = 0; i < 12; i++)
      add(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, (i < 11) ? 1'b1 : 1'b0, "r12_clear");
    add(1'b1, 1'b0, 1'b1, 4'd11, 8'h5A, 8'h5A, 1'b0, "r12_wr11");
    add(1'b1, 1'b0, 1'b1, 4'd13, 8'h99, 8'h00, 1'b0, "r12_wr13_oor");
    add(1'b1, 1'b0, 1'b0, 4'd13, 8'h00, 8'h00, 1'b0, "r12_rd13_oor");
    add(1'b1, 1'b0, 1'b0, 4'd11, 8'h00, 8'h5A, 1'b0, "r12_rd11");
    for (int i = 0; i < 12; i++)
      add(1'b1, 1'b0, 1'b0, 4'(i), 8'h00, (i == 11) ? 8'h5A : 8'h00, 1'b0, "r12_sweep");

    // Apply each vector on the falling edge, check just after the next rising edge.
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      if (vecs[k].sel == 1'b0) begin
        rst16 = vecs[k].rst; we16 = vecs[k].we; addr16 = vecs[k].addr; din16 = vecs[k].din;
      end else begin
        rst12 = vecs[k].rst; we12 = vecs[k].we; addr12 = vecs[k].addr; din12 = vecs[k].din;
      end
      e.idx = k; e.sel = vecs[k].sel; e.dout = vecs[k].exp_dout;
      e.busy = vecs[k].exp_busy; e.tag = vecs[k].tag;
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      got_d = (e.sel == 1'b0) ? dout16 : dout12;
      got_b = (e.sel == 1'b0) ? busy16 : busy12;
      n_cmp++;
      if (got_d !== e.dout) begin
        n_err++;
        $display("FAIL vec%0d %s data_out: got %h want %h", e.idx, e.tag, got_d, e.dout);
      end
      n_cmp++;
      if (got_b !== e.busy) begin
        n_err++;
        $display("FAIL vec%0d %s init_busy: got %b want %b", e.idx, e.tag, got_b, e.busy);
      end
    end

    // data_out must hold between edges: check mid-cycle after the last read.
    @(negedge clk);
    n_cmp++;
    if (dout12 !== 8'h5A) begin
      n_err++;
      $display("FAIL hold data_out: got %h want %h", dout12, 8'h5A);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
